// File: rtl/cuckoo_map_ctrl.sv
// cuckoo_map_ctrl: two-table cuckoo hash map (sva -> spa) held in flops.
// Each table has 2^LG_NUM_BUCKETS slots. The bucket index for table t is the
// top LG_NUM_BUCKETS bits of (upper*a_t + lower*b_t) mod 2^ADDR_WIDTH, where
// upper/lower are the halves of the key.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake; req_op 0=LOOKUP 1=PUT 2=REMOVE 3=reserved
//   req_sva, req_spa        key and value (value used by PUT only)
//   rsp_valid/rsp_ready     response handshake
//   rsp_status              0=OK 1=MISS 2=FULL 3=BADOP
//   rsp_hit                 key was present before the operation
//   rsp_sva, rsp_spa        key / old-or-found value (FULL: orphaned pair)
//   cfg_we, cfg_coe         in IDLE: load {a1,b1,a0,b0} and clear both tables
//   stat_*                  event counters
//
// Build option: define CUCKOO_MAP_STATS_EN to enable the saturating stat_*
// counters; otherwise the stat_* outputs are tied to zero.
module cuckoo_map_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned LG_NUM_BUCKETS = 2,
    parameter int unsigned MAX_KICKS      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_op,
    input  logic [ADDR_WIDTH-1:0]   req_sva,
    input  logic [ADDR_WIDTH-1:0]   req_spa,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [1:0]              rsp_status,
    output logic                    rsp_hit,
    output logic [ADDR_WIDTH-1:0]   rsp_sva,
    output logic [ADDR_WIDTH-1:0]   rsp_spa,
    input  logic                    cfg_we,
    input  logic [4*ADDR_WIDTH-1:0] cfg_coe,
    output logic [31:0]             stat_lookups,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_kicks,
    output logic [31:0]             stat_full
);
    localparam int unsigned AW   = ADDR_WIDTH;
    localparam int unsigned LG   = LG_NUM_BUCKETS;
    localparam int unsigned NB   = 1 << LG;
    localparam int unsigned LO_W = AW / 2;
    localparam int unsigned HI_W = AW - LO_W;
    localparam int unsigned KW   = $clog2(MAX_KICKS + 1);

    typedef logic [LG-1:0] idx_t;
    typedef enum logic [1:0] {S_IDLE, S_PROBE, S_KICK, S_RESP} state_t;
    typedef enum logic [1:0] {OP_LOOKUP, OP_PUT, OP_REMOVE, OP_RSVD} op_t;
    typedef enum logic [1:0] {ST_OK, ST_MISS, ST_FULL, ST_BADOP} status_t;

    // Top LG bits of the truncated product sum == sum >> (AW - LG).
    function automatic idx_t bucket(input logic [AW-1:0] key,
                                    input logic [AW-1:0] a,
                                    input logic [AW-1:0] b);
        logic [AW-1:0] upper;
        logic [AW-1:0] lower;
        logic [AW-1:0] sum;
        upper = {{LO_W{1'b0}}, key[AW-1:LO_W]};
        lower = {{HI_W{1'b0}}, key[LO_W-1:0]};
        sum   = upper * a + lower * b;
        return sum[AW-1 -: LG];
    endfunction

    state_t          state, state_next;
    op_t             op_q;
    logic [AW-1:0]   key_q, val_q;
    logic [AW-1:0]   coe_a0, coe_b0, coe_a1, coe_b1;
    logic            t_valid [2][NB];
    logic [AW-1:0]   t_sva   [2][NB];
    logic [AW-1:0]   t_spa   [2][NB];
    logic [AW-1:0]   carry_sva, carry_spa;
    logic            tgt;
    idx_t            kidx;
    logic [KW-1:0]   kcnt;
    status_t         rsp_status_q;

    // Combinational probe / kick views
    idx_t            idx0, idx1, nidx;
    logic            m0, m1, n_free;
    logic [AW-1:0]   hit_spa, occ_sva, occ_spa;

    // Control strobes from the FSM
    logic            accept, cfg_ld, rsp_ld, kick_start, kick_step;
    logic            wa_en, wa_tbl, wa_valid;
    idx_t            wa_idx;
    logic [AW-1:0]   wa_sva, wa_spa;
    logic            wb_en, wb_tbl;
    idx_t            wb_idx;
    status_t         rsp_status_d;
    logic            rsp_hit_d;
    logic [AW-1:0]   rsp_sva_d, rsp_spa_d;

    assign idx0    = bucket(key_q, coe_a0, coe_b0);
    assign idx1    = bucket(key_q, coe_a1, coe_b1);
    assign m0      = t_valid[0][idx0] && (t_sva[0][idx0] == key_q);
    assign m1      = t_valid[1][idx1] && (t_sva[1][idx1] == key_q);
    assign hit_spa = m0 ? t_spa[0][idx0] : t_spa[1][idx1];

    // The evicted occupant of the target slot goes to the other table.
    assign occ_sva = t_sva[tgt][kidx];
    assign occ_spa = t_spa[tgt][kidx];
    assign nidx    = tgt ? bucket(occ_sva, coe_a0, coe_b0)
                         : bucket(occ_sva, coe_a1, coe_b1);
    assign n_free  = !t_valid[~tgt][nidx];

    assign req_ready  = (state == S_IDLE) && !cfg_we;
    assign rsp_valid  = (state == S_RESP);
    assign rsp_status = rsp_status_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        cfg_ld       = 1'b0;
        rsp_ld       = 1'b0;
        kick_start   = 1'b0;
        kick_step    = 1'b0;
        wa_en        = 1'b0;
        wa_tbl       = 1'b0;
        wa_idx       = '0;
        wa_valid     = 1'b1;
        wa_sva       = key_q;
        wa_spa       = val_q;
        wb_en        = 1'b0;
        wb_tbl       = ~tgt;
        wb_idx       = nidx;
        rsp_status_d = ST_OK;
        rsp_hit_d    = 1'b0;
        rsp_sva_d    = key_q;
        rsp_spa_d    = '0;
        case (state)
            S_IDLE: begin
                if (cfg_we) begin
                    cfg_ld = 1'b1;
                end else if (req_valid) begin
                    accept     = 1'b1;
                    state_next = S_PROBE;
                end
            end
            S_PROBE: begin
                rsp_ld     = 1'b1;
                state_next = S_RESP;
                wa_tbl     = !m0;
                wa_idx     = m0 ? idx0 : idx1;
                case (op_q)
                    OP_LOOKUP, OP_REMOVE: begin
                        if (m0 || m1) begin
                            rsp_hit_d = 1'b1;
                            rsp_spa_d = hit_spa;
                            if (op_q == OP_REMOVE) begin
                                wa_en    = 1'b1;
                                wa_valid = 1'b0;
                                wa_spa   = hit_spa;
                            end
                        end else begin
                            rsp_status_d = ST_MISS;
                        end
                    end
                    OP_PUT: begin
                        if (m0 || m1) begin
                            wa_en     = 1'b1;
                            rsp_hit_d = 1'b1;
                            rsp_spa_d = hit_spa;
                        end else if (!t_valid[0][idx0]) begin
                            wa_en  = 1'b1;
                            wa_tbl = 1'b0;
                            wa_idx = idx0;
                        end else if (!t_valid[1][idx1]) begin
                            wa_en  = 1'b1;
                            wa_tbl = 1'b1;
                            wa_idx = idx1;
                        end else begin
                            rsp_ld     = 1'b0;
                            kick_start = 1'b1;
                            state_next = S_KICK;
                        end
                    end
                    default: rsp_status_d = ST_BADOP;
                endcase
            end
            S_KICK: begin
                // Carry takes the target slot; the occupant either lands in
                // a free slot of the other table or becomes the new carry.
                wa_en  = 1'b1;
                wa_tbl = tgt;
                wa_idx = kidx;
                wa_sva = carry_sva;
                wa_spa = carry_spa;
                if (n_free) begin
                    wb_en      = 1'b1;
                    rsp_ld     = 1'b1;
                    state_next = S_RESP;
                end else if (kcnt == KW'(MAX_KICKS - 1)) begin
                    rsp_ld       = 1'b1;
                    rsp_status_d = ST_FULL;
                    rsp_sva_d    = occ_sva;
                    rsp_spa_d    = occ_spa;
                    state_next   = S_RESP;
                end else begin
                    kick_step = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Valid bits, coefficients, request latch, kick state, response regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned t = 0; t < 2; t++)
                for (int unsigned i = 0; i < NB; i++)
                    t_valid[t][i] <= 1'b0;
            coe_a0       <= '0;
            coe_b0       <= '0;
            coe_a1       <= '0;
            coe_b1       <= '0;
            op_q         <= OP_LOOKUP;
            key_q        <= '0;
            val_q        <= '0;
            carry_sva    <= '0;
            carry_spa    <= '0;
            tgt          <= 1'b0;
            kidx         <= '0;
            kcnt         <= '0;
            rsp_status_q <= ST_OK;
            rsp_hit      <= 1'b0;
            rsp_sva      <= '0;
            rsp_spa      <= '0;
        end else begin
            if (cfg_ld) begin
                {coe_a1, coe_b1, coe_a0, coe_b0} <= cfg_coe;
                for (int unsigned t = 0; t < 2; t++)
                    for (int unsigned i = 0; i < NB; i++)
                        t_valid[t][i] <= 1'b0;
            end
            if (wa_en) t_valid[wa_tbl][wa_idx] <= wa_valid;
            if (wb_en) t_valid[wb_tbl][wb_idx] <= 1'b1;
            if (accept) begin
                op_q  <= op_t'(req_op);
                key_q <= req_sva;
                val_q <= req_spa;
            end
            if (kick_start) begin
                carry_sva <= key_q;
                carry_spa <= val_q;
                tgt       <= 1'b0;
                kidx      <= idx0;
                kcnt      <= '0;
            end else if (kick_step) begin
                carry_sva <= occ_sva;
                carry_spa <= occ_spa;
                tgt       <= ~tgt;
                kidx      <= nidx;
                kcnt      <= kcnt + 1'b1;
            end
            if (rsp_ld) begin
                rsp_status_q <= rsp_status_d;
                rsp_hit      <= rsp_hit_d;
                rsp_sva      <= rsp_sva_d;
                rsp_spa      <= rsp_spa_d;
            end
        end
    end

    // Slot payloads are only observed behind their valid bit.
    always_ff @(posedge clk) begin
        if (wa_en) begin
            t_sva[wa_tbl][wa_idx] <= wa_sva;
            t_spa[wa_tbl][wa_idx] <= wa_spa;
        end
        if (wb_en) begin
            t_sva[wb_tbl][wb_idx] <= occ_sva;
            t_spa[wb_tbl][wb_idx] <= occ_spa;
        end
    end

`ifdef CUCKOO_MAP_STATS_EN
    logic inc_lookup, inc_hit, inc_kick, inc_full;
    assign inc_lookup = (state == S_PROBE) && (op_q == OP_LOOKUP);
    assign inc_hit    = rsp_ld && rsp_hit_d;
    assign inc_kick   = (state == S_KICK);
    assign inc_full   = rsp_ld && (rsp_status_d == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lookups <= '0;
            stat_hits    <= '0;
            stat_kicks   <= '0;
            stat_full    <= '0;
        end else begin
            if (inc_lookup && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
            if (inc_hit    && stat_hits    != '1) stat_hits    <= stat_hits + 1'b1;
            if (inc_kick   && stat_kicks   != '1) stat_kicks   <= stat_kicks + 1'b1;
            if (inc_full   && stat_full    != '1) stat_full    <= stat_full + 1'b1;
        end
    end
`else
    assign stat_lookups = '0;
    assign stat_hits    = '0;
    assign stat_kicks   = '0;
    assign stat_full    = '0;
`endif

endmodule

// File: doc/cuckoo_map_ctrl.md
CUCKOO_MAP_CTRL -- requirements
Module: cuckoo_map_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: width of sva/spa.
REQ-002 SHALL have parameter LG_NUM_BUCKETS, default 2: log2 of entries per table; two tables.
REQ-003 SHALL have parameter MAX_KICKS, default 8: displacement limit per put.
REQ-004 SHALL have ports:
 - clk  in  1  sole clock, rising edge.
 - rst_n  in  1  asynchronous active-low reset.
 - req_valid  in  1  request present.
 - req_ready  out  1  block accepts request.
 - req_op  in  2  0=LOOKUP, 1=PUT, 2=REMOVE, 3=reserved.
 - req_sva  in  ADDR_WIDTH  key.
 - req_spa  in  ADDR_WIDTH  value (PUT only).
 - rsp_valid  out  1  response present.
 - rsp_ready  in  1  consumer accepts response.
 - rsp_status  out  2  0=OK, 1=MISS, 2=FULL, 3=BADOP.
 - rsp_hit  out  1  key was present before the op.
 - rsp_sva  out  ADDR_WIDTH  key returned (FULL: orphaned key).
 - rsp_spa  out  ADDR_WIDTH  old/found value (FULL: orphaned value).
 - cfg_we  in  1  load coefficients and clear both tables.
 - cfg_coe  in  4*ADDR_WIDTH  {a1,b1,a0,b0}.
 - stat_lookups, stat_hits, stat_kicks, stat_full  out  32 each  counters.

Function
REQ-005 SHALL compute table-t index = (upper*a_t + lower*b_t) mod 2^ADDR_WIDTH, shifted right by ADDR_WIDTH-LG_NUM_BUCKETS; upper/lower = sva halves.
REQ-006 SHALL store per table 2^LG_NUM_BUCKETS entries {valid, sva, spa} in flops.
REQ-007 SHALL implement FSM IDLE, PROBE, KICK, RESP; req_ready=1 only in IDLE, and only when cfg_we=0.
REQ-008 IDLE: req_valid&&req_ready latches request, -> PROBE.
REQ-009 PROBE (one cycle): read slot index0 of table0 and index1 of table1; key match = valid && sva equal.
REQ-010 LOOKUP: match -> OK, hit=1, spa of entry; else MISS, hit=0, spa=0; -> RESP. rsp_valid rises 2 cycles after acceptance.
REQ-011 REMOVE: match -> clear valid, OK, hit=1, old spa; else MISS; -> RESP.
REQ-012 PUT with match: overwrite spa in place, OK, hit=1, rsp_spa=old spa; -> RESP.
REQ-013 PUT without match: write table0 slot if empty, else table1 slot if empty (OK, hit=0); if both full -> KICK with carry=new pair, target table0.
REQ-014 KICK, per cycle: swap carry with target slot occupant, recompute carry's index in other table, toggle target; if that slot empty, write carry, OK -> RESP.
REQ-015 After MAX_KICKS swaps without empty slot SHALL -> RESP with FULL, rsp_sva/rsp_spa = final carry; table otherwise consistent.
REQ-016 req_op=3 SHALL -> RESP with BADOP, no table change.
REQ-017 RESP: hold all rsp_* stable with rsp_valid=1 until rsp_ready=1, then -> IDLE; next request accepted no earlier than the following cycle.
REQ-018 cfg_we in IDLE SHALL latch cfg_coe and clear all valid bits next edge; cfg_we outside IDLE SHALL be ignored; cfg_we and req_valid together: cfg_we wins, request not accepted.

Reset
REQ-019 rst_n low SHALL asynchronously force IDLE, all valid bits 0, coefficients 0, req_ready=1, rsp_valid=0, rsp_* = 0, counters 0.
REQ-020 Reset mid-PUT/KICK SHALL abort with no response; carry discarded.

Configuration
REQ-021 Macro CUCKOO_MAP_STATS_EN defined: stat_lookups +1 per LOOKUP, stat_hits +1 per hit response, stat_kicks +1 per KICK swap, stat_full +1 per FULL; all saturate at 2^32-1; cleared by reset only.
REQ-022 CUCKOO_MAP_STATS_EN undefined: stat_* ports present, tied 0, no counter logic.

Verification
REQ-023 Coe all 1, PUT sva=0x10 spa=0xA, LOOKUP 0x10 -> OK, hit=1, rsp_spa=0xA, rsp_valid 2 cycles after accept.
REQ-024 PUT 0x10 spa=0xB over existing 0xA -> OK, hit=1, rsp_spa=0xA; LOOKUP -> 0xB.
REQ-025 Coe all 0 (every key index 0), PUT keys 1,2,3 -> third PUT runs KICK, ends FULL after 8 swaps with rsp_sva/rsp_spa = orphaned pair, stat_full=1.
REQ-026 REMOVE absent key 0x20 -> MISS, hit=0; req_op=3 -> BADOP, table unchanged.
REQ-027 Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0; cfg_we asserted during RESP ignored.
REQ-028 Drop rst_n during KICK -> no rsp_valid, all LOOKUPs afterward MISS, counters 0.
